// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 multicycle controller and its datapath.
// State codes, opcode fields, instruction classes and ALU operation codes.
package cr16_pkg;

    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_LATCH = 4'd1;
    localparam logic [3:0] S_EXEC  = 4'd2;
    localparam logic [3:0] S_SHIFT = 4'd3;
    localparam logic [3:0] S_WB    = 4'd4;
    localparam logic [3:0] S_LDADR = 4'd5;
    localparam logic [3:0] S_LDWB  = 4'd6;
    localparam logic [3:0] S_STORE = 4'd7;
    localparam logic [3:0] S_JUMP  = 4'd8;
    localparam logic [3:0] S_PCINC = 4'd9;
    localparam logic [3:0] S_HALT  = 4'd10;

    typedef enum logic [2:0] {
        C_ALU, C_SHIFT, C_LOAD, C_STOR, C_JUMP, C_NOP
    } iclass_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MEM   = 4'b0100;

    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_NOP  = 4'b0000;
    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_JUMP = 4'b1100;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_PASSA = 4'd5;

endpackage

// File: rtl/cr16_decode.sv
// Combinational instruction decode: opcode fields to class, ALU op,
// immediate/sign-extension flags and an illegal-encoding flag.
module cr16_decode
    import cr16_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] ext,
    output iclass_t    iclass,
    output logic [3:0] alu,
    output logic       imm,
    output logic       sign,
    output logic       illegal
);

    always_comb begin
        iclass  = C_NOP;
        alu     = ALU_ADD;
        imm     = 1'b0;
        sign    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass = C_ALU;
                case (ext)
                    EXT_ADD: alu = ALU_ADD;
                    EXT_SUB: alu = ALU_SUB;
                    EXT_AND: alu = ALU_AND;
                    EXT_OR:  alu = ALU_OR;
                    EXT_XOR: alu = ALU_XOR;
                    EXT_MOV: alu = ALU_PASSA;
                    EXT_NOP: iclass = C_NOP;
                    default: begin
                        iclass  = C_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                iclass = C_ALU;
                imm    = 1'b1;
                sign   = 1'b1;
            end
            OP_SUBI: begin
                iclass = C_ALU;
                alu    = ALU_SUB;
                imm    = 1'b1;
                sign   = 1'b1;
            end
            OP_MOVI: begin
                iclass = C_ALU;
                alu    = ALU_PASSA;
                imm    = 1'b1;
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    iclass = C_SHIFT;
                end else if (ext[3:1] == 3'b000) begin
                    // LSHI: signed immediate shift amount
                    iclass = C_SHIFT;
                    imm    = 1'b1;
                    sign   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_MEM: begin
                case (ext)
                    EXT_LOAD: iclass = C_LOAD;
                    EXT_STOR: iclass = C_STOR;
                    EXT_JUMP: iclass = C_JUMP;
                    default:  illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cr16_controller.sv
// Multicycle control FSM for the 16-bit CR16 datapath.
// Moore outputs decoded from the state and the opcode latched in LATCH.
module cr16_controller
    import cr16_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] OpCode,
    input  logic [3:0] OpCodeExt,
    output logic [3:0] aluControl,
    output logic       pcRegEn,
    output logic       srcRegEn,
    output logic       dstRegEn,
    output logic       immRegEn,
    output logic       resultRegEn,
    output logic       regFileEn,
    output logic       signEn,
    output logic       irS,
    output logic       exMemResultEn,
    output logic       pcRegMuxEn,
    output logic [1:0] mux4En,
    output logic       shiftALUMuxEn,
    output logic       regImmMuxEn,
    output logic [1:0] regpcCont,
    output logic       memWrite,
    output logic       halted,
    output logic [3:0] state
);

    logic [3:0] op_q, ext_q, dec_op, dec_ext, nxt;
    logic [3:0] d_alu;
    logic       d_imm, d_sign, d_ill;
    iclass_t    d_class;

    // In LATCH the live fields steer the branch; afterwards the copy does.
    assign dec_op  = (state == S_LATCH) ? OpCode    : op_q;
    assign dec_ext = (state == S_LATCH) ? OpCodeExt : ext_q;

    cr16_decode u_dec (
        .op      (dec_op),
        .ext     (dec_ext),
        .iclass  (d_class),
        .alu     (d_alu),
        .imm     (d_imm),
        .sign    (d_sign),
        .illegal (d_ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            op_q  <= 4'b0000;
            ext_q <= 4'b0000;
        end else begin
            state <= nxt;
            if (state == S_LATCH) begin
                op_q  <= OpCode;
                ext_q <= OpCodeExt;
            end
        end
    end

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH: nxt = S_LATCH;
            S_LATCH: begin
                if (d_ill) begin
                    nxt = HALT_ON_ILLEGAL ? S_HALT : S_PCINC;
                end else begin
                    case (d_class)
                        C_ALU:   nxt = S_EXEC;
                        C_SHIFT: nxt = S_SHIFT;
                        C_LOAD:  nxt = S_LDADR;
                        C_STOR:  nxt = S_STORE;
                        C_JUMP:  nxt = S_JUMP;
                        default: nxt = S_PCINC;
                    endcase
                end
            end
            S_EXEC, S_SHIFT:        nxt = S_WB;
            S_WB, S_LDWB, S_STORE:  nxt = S_PCINC;
            S_LDADR:                nxt = S_LDWB;
            S_JUMP, S_PCINC:        nxt = S_FETCH;
            S_HALT:                 nxt = S_HALT;
            default:                nxt = S_FETCH;
        endcase
    end

    always_comb begin
        aluControl    = ALU_ADD;
        pcRegEn       = 1'b0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        resultRegEn   = 1'b0;
        regFileEn     = 1'b0;
        signEn        = 1'b0;
        irS           = 1'b0;
        exMemResultEn = 1'b0;
        pcRegMuxEn    = 1'b0;
        mux4En        = 2'd0;
        shiftALUMuxEn = 1'b0;
        regImmMuxEn   = 1'b0;
        regpcCont     = 2'd0;
        memWrite      = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: regpcCont = 2'd1;
            S_LATCH: begin
                irS      = 1'b1;
                srcRegEn = 1'b1;
                dstRegEn = 1'b1;
                immRegEn = 1'b1;
            end
            S_EXEC: begin
                resultRegEn = 1'b1;
                pcRegMuxEn  = 1'b1;
                aluControl  = d_alu;
                mux4En      = d_imm ? 2'd1 : 2'd0;
                signEn      = d_sign;
            end
            S_SHIFT: begin
                resultRegEn   = 1'b1;
                shiftALUMuxEn = 1'b1;
                regImmMuxEn   = d_imm;
                signEn        = d_sign;
            end
            S_WB:    regFileEn = 1'b1;
            S_LDADR: regpcCont = 2'd0;
            S_LDWB: begin
                exMemResultEn = 1'b1;
                regFileEn     = 1'b1;
            end
            S_STORE: memWrite = 1'b1;
            S_JUMP: begin
                mux4En     = 2'd3;
                pcRegMuxEn = 1'b1;
                pcRegEn    = 1'b1;
            end
            S_PCINC: begin
                mux4En  = 2'd2;
                pcRegEn = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: regpcCont = 2'd0;
        endcase
    end

endmodule
